uart_tx_mmio: RTL and testbench
===============================

Name: uart_tx_mmio

Overview:
- Transmit end of the memory-mapped UART port. The dual-issue memory-access stage suppresses RAM writes to `UART_ADDR`; this block consumes exactly those stores.
- It watches both store slots (EX1, EX2) and queues byte lane 0 of every UART store into a 2-write/1-read FIFO.
- It serialises queued bytes as 8N1 frames on `uart_tx`.
- It sits beside the memory-access stage and feeds an upstream stall request back to the issue logic.

Parameters:
- CLK_PER_BIT, 868, clock cycles per bit (100 MHz / 115200). Must be ≥2.
- FIFO_DEPTH, 16, FIFO entries. Must be a power of 2 and ≥4.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- write_en_bmEX1  in  4  slot-1 store byte mask
- write_addressEX1  in  32  slot-1 store address
- storevalue_wordEX1  in  32  slot-1 store data
- write_en_bmEX2  in  4  slot-2 store byte mask
- write_addressEX2  in  32  slot-2 store address
- storevalue_wordEX2  in  32  slot-2 store data
- uart_tx  out  1  serial line, idle high
- tx_busy  out  1  frame in progress or FIFO non-empty
- fifo_full  out  1  stall request: free entries < 2
- fifo_overflow  out  1  sticky, a byte was dropped
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy

Behaviour:
- Reset values (asynchronous on rst low):
  - uart_tx=1, tx_busy=0, fifo_full=0, fifo_overflow=0, fifo_count=0.
  - FIFO pointers 0; FSM in IDLE; baud counter 0; bit index 0.
- Store hit:
  - hitN = (write_addressEX{N} == `UART_ADDR`) && write_en_bmEX{N}[0].
  - Other mask bits are ignored. Data is storevalue_wordEX{N}[7:0].
- Enqueue order:
  - Hits are sampled every posedge.
  - If both slots hit in one cycle, the slot-1 byte goes before the slot-2 byte.
- Free-slot accounting:
  - free = FIFO_DEPTH − count, using count before this edge's pop.
  - Pushes are accepted in order while free > 0. Remaining hits are dropped and set fifo_overflow, which clears only on reset.
- Count update: count_next = count + accepted pushes − pop. Simultaneous push and pop is legal, including at full and at empty+push.
- Flags are registered from count_next:
  - fifo_full = (FIFO_DEPTH − count_next < 2).
  - tx_busy = (state != IDLE) || (count_next != 0).
- Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, STOP. All four drive uart_tx from a register.
  - IDLE: uart_tx=1. If count ≠ 0: pop the head into the shift register, go to START, baud counter = 0.
  - START: uart_tx=0 for CLK_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: uart_tx = shift[0], LSB first. After each CLK_PER_BIT cycles, shift right and increment the bit index. After bit 7, go to STOP.
  - STOP: uart_tx=1 for CLK_PER_BIT cycles. At the end, if count ≠ 0, pop and go straight to START (no idle gap); otherwise go to IDLE.
- Baud counter: counts 0..CLK_PER_BIT−1, then wraps and advances the bit; it resets to 0 on every state entry.
- Latency: a byte enqueued at edge k (FIFO was empty, FSM IDLE) pops at edge k+1, and uart_tx falls after edge k+1.
- Frame length is exactly 10·CLK_PER_BIT cycles.
- Reset mid-frame: uart_tx returns high immediately, the FIFO is emptied, and the partial frame is abandoned.
- Stores to `UART_ADDR` never reach RAM; that is guaranteed by the memory-access stage, not by this block.

Decomposition:
- `UART_ADDR` stays in define.vh.
- Add FSM state encodings (UTX_IDLE=2'd0, UTX_START=2'd1, UTX_DATA=2'd2, UTX_STOP=2'd3) to define.vh.
- One sub-module, uart_tx_fifo:
  - 2 write ports (ordered), 1 read port.
  - Provides count and full/overflow logic.
  - Parameterised by FIFO_DEPTH, width 8.
- The FSM and baud counter live in uart_tx_mmio.

Test Plan:
- CLK_PER_BIT=4, slot-1 store 0x00000055, mask 4'b0001 to `UART_ADDR` → uart_tx falls 1 cycle after the store edge. Then 0,1,0,1,0,1,0,1,0,1 with 4 cycles per bit; tx_busy drops after 40 cycles; fifo_count returns to 0.
- Same cycle: slot-1 0x41 and slot-2 0x42, both to `UART_ADDR` → 'A' frame then 'B' frame back-to-back, 80 cycles total, no high gap between STOP and the second START.
- Store with mask 4'b0010 to `UART_ADDR`, and a store with mask 4'b1111 to `UART_ADDR`+4 → nothing enqueued, uart_tx stays 1, fifo_count=0.
- FIFO_DEPTH=4, long CLK_PER_BIT, 3 single stores → fifo_full asserts once count hits 3. Then a dual store with 1 free → slot-1 accepted, slot-2 dropped, fifo_overflow=1 and stays 1.
- Dual store while the FSM pops in the same cycle (count=1) → count becomes 2; byte order preserved.
- rst low during bit 3 of a frame with 2 bytes queued → uart_tx=1 and fifo_count=0 immediately; after release, the line stays idle with no further frames.

Source files
------------

// File: rtl/uart_tx_mmio_pkg.sv
// Shared constants and types for the memory-mapped UART transmitter.
// Holds the UART store address and the transmit FSM encodings.
package uart_tx_mmio_pkg;

    localparam logic [31:0] UART_ADDR = 32'h1000_0000;

    typedef enum logic [1:0] {
        UTX_IDLE  = 2'd0,
        UTX_START = 2'd1,
        UTX_DATA  = 2'd2,
        UTX_STOP  = 2'd3
    } utx_state_t;

    function automatic logic store_hit(
        input logic        en0,
        input logic [31:0] addr
    );
        return (addr == UART_ADDR) && en0;
    endfunction

endpackage

// File: rtl/uart_tx_mmio_if.sv
// Store bus from the dual-issue memory-access stage (slots EX1 and EX2).
// The pipeline drives it as master; the UART port observes it as slave.
interface uart_tx_mmio_if;

    logic [3:0]  write_en_bmEX1;
    logic [31:0] write_addressEX1;
    logic [31:0] storevalue_wordEX1;
    logic [3:0]  write_en_bmEX2;
    logic [31:0] write_addressEX2;
    logic [31:0] storevalue_wordEX2;

    modport master (
        output write_en_bmEX1, write_addressEX1, storevalue_wordEX1,
        output write_en_bmEX2, write_addressEX2, storevalue_wordEX2
    );

    modport slave (
        input write_en_bmEX1, write_addressEX1, storevalue_wordEX1,
        input write_en_bmEX2, write_addressEX2, storevalue_wordEX2
    );

endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO with two ordered write ports and one read port.
// Port A always wins the last free entry; rejected pushes set a sticky overflow.
module uart_tx_fifo #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push_a,
    input  logic [7:0]                  data_a,
    input  logic                        push_b,
    input  logic [7:0]                  data_b,
    input  logic                        pop,
    output logic [7:0]                  head,
    output logic [$clog2(FIFO_DEPTH):0] count,
    output logic [$clog2(FIFO_DEPTH):0] count_next,
    output logic                        full,
    output logic                        overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_b;
    logic [CW-1:0] free;
    logic          acc_a;
    logic          acc_b;
    logic          pop_ok;
    logic          drop;

    // Free space is taken before this edge's pop, so a full FIFO never
    // accepts a push even while it drains.
    assign free       = DEPTH_C - count;
    assign acc_a      = push_a && (free != '0);
    assign acc_b      = push_b && (free > CW'(acc_a));
    assign drop       = (push_a && !acc_a) || (push_b && !acc_b);
    assign pop_ok     = pop && (count != '0);
    assign wr_b       = wr_ptr + AW'(acc_a);
    assign head       = mem[rd_ptr];
    assign count_next = count + CW'(acc_a) + CW'(acc_b) - CW'(pop_ok);

    always_ff @(posedge clk) begin
        if (acc_a) mem[wr_ptr] <= data_a;
        if (acc_b) mem[wr_b]   <= data_b;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            wr_ptr   <= wr_ptr + AW'(acc_a) + AW'(acc_b);
            rd_ptr   <= rd_ptr + AW'(pop_ok);
            count    <= count_next;
            full     <= count_next > (DEPTH_C - CW'(2));
            overflow <= overflow | drop;
        end
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// Transmit side of the memory-mapped UART: captures stores to UART_ADDR
// from both issue slots and sends them as 8N1 frames on uart_tx.
module uart_tx_mmio #(
    parameter int CLK_PER_BIT = 868,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    uart_tx_mmio_if.slave               bus,
    output logic                        uart_tx,
    output logic                        tx_busy,
    output logic                        fifo_full,
    output logic                        fifo_overflow,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    import uart_tx_mmio_pkg::*;

    localparam int BW = $clog2(CLK_PER_BIT);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    utx_state_t    state, state_n;
    logic [BW-1:0] baud, baud_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    shift, shift_n;
    logic          tx_n;
    logic          pop;
    logic          baud_end;
    logic          hit1, hit2;
    logic [7:0]    head;
    logic [CW-1:0] count_next;
    logic          unused_bits;

    assign hit1 = store_hit(bus.write_en_bmEX1[0], bus.write_addressEX1);
    assign hit2 = store_hit(bus.write_en_bmEX2[0], bus.write_addressEX2);
    assign unused_bits = ^{bus.write_en_bmEX1[3:1], bus.write_en_bmEX2[3:1],
                           bus.storevalue_wordEX1[31:8],
                           bus.storevalue_wordEX2[31:8]};

    uart_tx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_a     (hit1),
        .data_a     (bus.storevalue_wordEX1[7:0]),
        .push_b     (hit2),
        .data_b     (bus.storevalue_wordEX2[7:0]),
        .pop        (pop),
        .head       (head),
        .count      (fifo_count),
        .count_next (count_next),
        .full       (fifo_full),
        .overflow   (fifo_overflow)
    );

    assign baud_end = (baud == BW'(CLK_PER_BIT - 1));

    always_comb begin
        state_n   = state;
        baud_n    = baud_end ? '0 : baud + BW'(1);
        bit_idx_n = bit_idx;
        shift_n   = shift;
        pop       = 1'b0;
        unique case (state)
            UTX_IDLE: begin
                baud_n = '0;
                if (fifo_count != '0) begin
                    pop     = 1'b1;
                    shift_n = head;
                    state_n = UTX_START;
                end
            end
            UTX_START: begin
                if (baud_end) begin
                    state_n   = UTX_DATA;
                    bit_idx_n = 3'd0;
                end
            end
            UTX_DATA: begin
                if (baud_end) begin
                    shift_n   = shift >> 1;
                    bit_idx_n = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_n = UTX_STOP;
                end
            end
            UTX_STOP: begin
                // Chain straight into the next START so frames abut.
                if (baud_end) begin
                    if (fifo_count != '0) begin
                        pop     = 1'b1;
                        shift_n = head;
                        state_n = UTX_START;
                    end else begin
                        state_n = UTX_IDLE;
                    end
                end
            end
            default: state_n = UTX_IDLE;
        endcase

        unique case (state_n)
            UTX_START: tx_n = 1'b0;
            UTX_DATA:  tx_n = shift_n[0];
            default:   tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= UTX_IDLE;
            baud    <= '0;
            bit_idx <= 3'd0;
            shift   <= 8'd0;
            uart_tx <= 1'b1;
            tx_busy <= 1'b0;
        end else begin
            state   <= state_n;
            baud    <= baud_n;
            bit_idx <= bit_idx_n;
            shift   <= shift_n;
            uart_tx <= tx_n;
            tx_busy <= (state_n != UTX_IDLE) || (count_next != '0);
        end
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Bench for uart_tx_mmio: directed and random stores against a queue-based
// model that treats the transmitter as a server with 10-bit-time service.
module tb_uart_tx_mmio;

    import uart_tx_mmio_pkg::*;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       uart_tx, tx_busy, fifo_full, fifo_overflow;
    logic [2:0] fifo_count;

    uart_tx_mmio_if bus ();

    uart_tx_mmio #(
        .CLK_PER_BIT (CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .uart_tx       (uart_tx),
        .tx_busy       (tx_busy),
        .fifo_full     (fifo_full),
        .fifo_overflow (fifo_overflow),
        .fifo_count    (fifo_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] mq[$];
    int         cyc       = 0;
    int         next_free = 0;
    int         cur_start = 0;
    logic [7:0] cur_byte  = 8'd0;
    logic       m_ovf     = 1'b0;

    function automatic logic [6:0] got();
        return {uart_tx, tx_busy, fifo_full, fifo_overflow, fifo_count};
    endfunction

    // Line level from the position inside the current frame:
    // slot 0 start, slots 1..8 data LSB first, slot 9 stop.
    function automatic logic [6:0] expv();
        logic tx;
        int   off, b;
        tx = 1'b1;
        if (cyc < next_free) begin
            off = cyc - cur_start;
            b   = off / CPB;
            if (b == 0) tx = 1'b0;
            else if (b <= 8) tx = cur_byte[b-1];
        end
        return {tx, (cyc < next_free) || (mq.size() != 0),
                (DEPTH - mq.size()) < 2, m_ovf, 3'(mq.size())};
    endfunction

    task automatic drive(input logic [3:0] bm1, input logic [31:0] a1,
                         input logic [31:0] d1, input logic [3:0] bm2,
                         input logic [31:0] a2, input logic [31:0] d2);
        bus.write_en_bmEX1     = bm1;
        bus.write_addressEX1   = a1;
        bus.storevalue_wordEX1 = d1;
        bus.write_en_bmEX2     = bm2;
        bus.write_addressEX2   = a2;
        bus.storevalue_wordEX2 = d2;
    endtask

    task automatic idle();
        drive(4'd0, 32'd0, 32'd0, 4'd0, 32'd0, 32'd0);
    endtask

    task automatic step();
        logic h1, h2;
        int   pre, free;
        @(posedge clk);
        cyc++;
        h1   = (bus.write_addressEX1 == UART_ADDR) && bus.write_en_bmEX1[0];
        h2   = (bus.write_addressEX2 == UART_ADDR) && bus.write_en_bmEX2[0];
        pre  = mq.size();
        free = DEPTH - pre;
        if (h1) begin
            if (free > 0) begin
                mq.push_back(bus.storevalue_wordEX1[7:0]);
                free--;
            end else m_ovf = 1'b1;
        end
        if (h2) begin
            if (free > 0) begin
                mq.push_back(bus.storevalue_wordEX2[7:0]);
                free--;
            end else m_ovf = 1'b1;
        end
        if (pre > 0 && cyc >= next_free) begin
            cur_byte  = mq.pop_front();
            cur_start = cyc;
            next_free = cyc + 10 * CPB;
        end
        #1;
    endtask

    task automatic do_reset();
        #2 rst = 1'b0;
        idle();
        mq.delete();
        next_free = 0;
        m_ovf     = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (got() !== 7'b1000000)
            $display("FAIL reset: got %b expected %b", got(), 7'b1000000);
        else n_pass++;
    endtask

    task automatic test_single();
        int s, drop;
        do_reset();
        drive(4'b0001, UART_ADDR, 32'h0000_0055, 4'd0, 32'd0, 32'd0);
        step();
        s = cyc;
        drop = 0;
        idle();
        for (int i = 0; i < 48; i++) begin
            step();
            n_checks++;
            if (got() !== expv())
                $display("FAIL single c%0d: got %b expected %b",
                         cyc, got(), expv());
            else n_pass++;
            if (!tx_busy && drop == 0) drop = cyc - s;
        end
        n_checks++;
        if (drop !== 41)
            $display("FAIL single_busy_drop: got %0d expected %0d", drop, 41);
        else n_pass++;
    endtask

    task automatic test_dual();
        do_reset();
        drive(4'b0001, UART_ADDR, 32'h41, 4'b0001, UART_ADDR, 32'h42);
        step();
        idle();
        for (int i = 0; i < 88; i++) begin
            step();
            n_checks++;
            if (got() !== expv())
                $display("FAIL dual c%0d: got %b expected %b",
                         cyc, got(), expv());
            else n_pass++;
        end
    endtask

    task automatic test_nohit();
        do_reset();
        drive(4'b0010, UART_ADDR, 32'h77, 4'b1111, UART_ADDR + 32'd4, 32'h99);
        step();
        idle();
        for (int i = 0; i < 10; i++) begin
            step();
            n_checks++;
            if (got() !== expv())
                $display("FAIL nohit c%0d: got %b expected %b",
                         cyc, got(), expv());
            else n_pass++;
        end
        n_checks++;
        if (fifo_count !== 3'd0 || uart_tx !== 1'b1)
            $display("FAIL nohit_idle: got cnt=%0d tx=%b expected cnt=0 tx=1",
                     fifo_count, uart_tx);
        else n_pass++;
    endtask

    task automatic test_overflow();
        do_reset();
        drive(4'b0001, UART_ADDR, 32'h10, 4'd0, 32'd0, 32'd0);
        step();
        idle();
        step();
        for (int i = 0; i < 3; i++) begin
            drive(4'b0001, UART_ADDR, 32'(8'h20 + i), 4'd0, 32'd0, 32'd0);
            step();
        end
        n_checks++;
        if (fifo_full !== 1'b1 || fifo_count !== 3'd3)
            $display("FAIL full_at_3: got full=%b cnt=%0d expected full=1 cnt=3",
                     fifo_full, fifo_count);
        else n_pass++;
        drive(4'b0001, UART_ADDR, 32'hC1, 4'b0001, UART_ADDR, 32'hC2);
        step();
        idle();
        n_checks++;
        if (fifo_overflow !== 1'b1 || fifo_count !== 3'd4)
            $display("FAIL overflow: got ovf=%b cnt=%0d expected ovf=1 cnt=4",
                     fifo_overflow, fifo_count);
        else n_pass++;
        for (int i = 0; i < 200; i++) begin
            step();
            n_checks++;
            if (got() !== expv())
                $display("FAIL ovf_drain c%0d: got %b expected %b",
                         cyc, got(), expv());
            else n_pass++;
        end
    endtask

    task automatic test_pop_push();
        do_reset();
        drive(4'b0001, UART_ADDR, 32'h5A, 4'd0, 32'd0, 32'd0);
        step();
        drive(4'b0001, UART_ADDR, 32'hA5, 4'b0001, UART_ADDR, 32'h3C);
        step();
        idle();
        n_checks++;
        if (fifo_count !== 3'd2)
            $display("FAIL pop_push_cnt: got %0d expected %0d", fifo_count, 2);
        else n_pass++;
        for (int i = 0; i < 125; i++) begin
            step();
            n_checks++;
            if (got() !== expv())
                $display("FAIL pop_push c%0d: got %b expected %b",
                         cyc, got(), expv());
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [3:0]  bm1, bm2;
        logic [31:0] a1, a2;
        do_reset();
        for (int i = 0; i < 900; i++) begin
            bm1 = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'd0;
            bm2 = ($urandom_range(0, 12) == 0) ? 4'($urandom) : 4'd0;
            a1  = ($urandom_range(0, 3) == 0) ? UART_ADDR + 32'd4 : UART_ADDR;
            a2  = ($urandom_range(0, 3) == 0) ? 32'($urandom) : UART_ADDR;
            drive(bm1, a1, 32'($urandom), bm2, a2, 32'($urandom));
            step();
            n_checks++;
            if (got() !== expv())
                $display("FAIL random c%0d: got %b expected %b",
                         cyc, got(), expv());
            else n_pass++;
        end
        idle();
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(4'b0001, UART_ADDR, 32'hF0, 4'd0, 32'd0, 32'd0);
        step();
        drive(4'b0001, UART_ADDR, 32'h0F, 4'b0001, UART_ADDR, 32'h81);
        step();
        idle();
        for (int i = 0; i < 16; i++) step();
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if (got() !== 7'b1000000)
            $display("FAIL reset_mid: got %b expected %b", got(), 7'b1000000);
        else n_pass++;
        mq.delete();
        next_free = 0;
        m_ovf     = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 60; i++) begin
            step();
            n_checks++;
            if (got() !== 7'b1000000)
                $display("FAIL reset_mid_idle c%0d: got %b expected %b",
                         cyc, got(), 7'b1000000);
            else n_pass++;
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_single();
        test_dual();
        test_nohit();
        test_overflow();
        test_pop_push();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
